// File: rtl/udma_qspi_cmd_arbiter.sv
// Round-robin, transaction-locked arbiter sharing the SPIM command channel between NB_REQ requesters.
// Optional EOT watchdog enabled by defining QSPI_ARB_TIMEOUT_EN (adds timeout_o).
module udma_qspi_cmd_arbiter #(
  parameter int NB_REQ         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NB_REQ-1:0]            req_valid_i,
  input  logic [NB_REQ-1:0]            req_last_i,
  output logic [NB_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]        cmd_data_o,
  output logic                         cmd_valid_o,
  input  logic                         cmd_ready_i,
  input  logic                         spi_eot_i,
  output logic                         busy_o,
  output logic [$clog2(NB_REQ)-1:0]    owner_o,
  output logic [NB_REQ-1:0]            done_o
`ifdef QSPI_ARB_TIMEOUT_EN
  ,
  output logic                         timeout_o
`endif
);

  localparam int OW = $clog2(NB_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     rr_ptr;
  logic [OW-1:0]     pick;
  logic [OW-1:0]     owner_inc;
  logic [NB_REQ-1:0] owner_oh;
  logic              wd_expire;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NB_REQ;
      if (!found && req_valid_i[idx]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    owner_inc       = (owner == OW'(NB_REQ - 1)) ? '0 : owner + OW'(1);
  end

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_data_o  = '0;
    req_ready_o = '0;
    if (state == ST_XFER) begin
      cmd_valid_o        = req_valid_i[owner];
      req_ready_o[owner] = cmd_ready_i;
      if (req_valid_i[owner]) begin
        cmd_data_o = req_data_i[owner*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy_o  = (state != ST_IDLE);
  assign owner_o = owner;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] wd_cnt;

  // EOT on the expiry cycle takes precedence, so expiry is gated by spi_eot_i.
  assign wd_expire = (state == ST_WAIT) && !spi_eot_i &&
                     (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= wd_expire;
      if (state != ST_WAIT) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + CW'(1);
      end
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      done_o <= '0;
    end else begin
      done_o <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid_i) begin
            owner <= pick;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (cmd_valid_o && cmd_ready_i && req_last_i[owner]) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (spi_eot_i) begin
            done_o <= owner_oh;
            rr_ptr <= owner_inc;
            state  <= ST_IDLE;
          end else if (wd_expire) begin
            rr_ptr <= owner_inc;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_qspi_cmd_arbiter.sv
// Randomized scoreboard bench for udma_qspi_cmd_arbiter: a transaction-level reference model
// predicts grants, accepted words, ready/valid visibility and done pulses cycle by cycle.
module tb_udma_qspi_cmd_arbiter;

  localparam int NB_REQ = 4;
  localparam int DW     = 32;
  localparam int N_TXN  = 12;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NB_REQ*DW-1:0]     req_data_i;
  logic [NB_REQ-1:0]        req_valid_i;
  logic [NB_REQ-1:0]        req_last_i;
  logic [NB_REQ-1:0]        req_ready_o;
  logic [DW-1:0]            cmd_data_o;
  logic                     cmd_valid_o;
  logic                     cmd_ready_i;
  logic                     spi_eot_i;
  logic                     busy_o;
  logic [1:0]               owner_o;
  logic [NB_REQ-1:0]        done_o;
`ifdef QSPI_ARB_TIMEOUT_EN
  logic                     timeout_o;
`endif

  udma_qspi_cmd_arbiter #(.NB_REQ(NB_REQ), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4096)) dut (
    .sys_clk_i   (clk),
    .rst_i       (rst),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .spi_eot_i   (spi_eot_i),
    .busy_o      (busy_o),
    .owner_o     (owner_o),
    .done_o      (done_o)
`ifdef QSPI_ARB_TIMEOUT_EN
    ,
    .timeout_o   (timeout_o)
`endif
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  word_t exp_q[NB_REQ][$];
  word_t drv_q[NB_REQ][$];
  int    started[NB_REQ];
  int    seq = 0;
  int    obs_log[$];

  int          m_phase = 0;   // 0 idle, 1 transferring, 2 waiting for EOT
  logic [1:0]  m_owner = '0;
  logic [1:0]  m_ptr   = '0;
  logic [3:0]  done_next = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr_first(input logic [3:0] v, input logic [1:0] p);
    for (int k = 0; k < NB_REQ; k++) begin
      int j;
      j = (int'(p) + k) % NB_REQ;
      if (v[j]) return 2'(j);
    end
    return p;
  endfunction

  // Monitor and reference model
  initial begin
    forever begin
      logic        e_valid;
      logic [3:0]  e_ready;
      logic [31:0] e_data;
      word_t       w;
      @(negedge clk);
      if (rst) begin
        chk("rst_cmd_valid", cmd_valid_o, 0);
        chk("rst_cmd_data", cmd_data_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_done", done_o, 0);
        m_phase = 0; m_owner = '0; m_ptr = '0; done_next = '0;
        for (int i = 0; i < NB_REQ; i++) exp_q[i].delete();
      end else begin
        e_valid = (m_phase == 1) && req_valid_i[m_owner];
        e_ready = '0;
        if (m_phase == 1 && cmd_ready_i) e_ready[m_owner] = 1'b1;
        e_data = '0;
        if (e_valid) begin
          if (exp_q[m_owner].size() == 0) chk("sb_underflow", 1, 0);
          else e_data = exp_q[m_owner][0].data;
        end
        chk("cmd_valid", cmd_valid_o, e_valid);
        chk("cmd_data", cmd_data_o, e_data);
        chk("req_ready", req_ready_o, e_ready);
        chk("busy", busy_o, m_phase != 0);
        chk("owner", owner_o, m_owner);
        chk("done", done_o, done_next);
        done_next = '0;
        case (m_phase)
          0: if (|req_valid_i) begin
               m_owner = rr_first(req_valid_i, m_ptr);
               m_phase = 1;
             end
          1: if (e_valid && cmd_ready_i && exp_q[m_owner].size() > 0) begin
               w = exp_q[m_owner].pop_front();
               if (w.data[15:12] == 4'd0) obs_log.push_back(int'(w.data[31:28]));
               if (w.last) m_phase = 2;
             end
          default: if (spi_eot_i) begin
               done_next[m_owner] = 1'b1;
               m_ptr   = 2'((int'(m_owner) + 1) % NB_REQ);
               m_phase = 0;
             end
        endcase
      end
    end
  end

  task automatic new_txn(input int r, input int n);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.data = {4'(r), 12'(seq), 4'(k), 12'($urandom)};
      w.last = (k == n - 1);
      drv_q[r].push_back(w);
      exp_q[r].push_back(w);
    end
    seq++;
    started[r]++;
  endtask

  // eot_mode: 0 random pulses, 1 pulse whenever waiting for EOT, 2 never
  task automatic drive_cycle(input int valid_pct, input int ready_pct, input int eot_mode);
    logic [3:0] acc;
    @(negedge clk);
    acc = req_valid_i & req_ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NB_REQ; i++) begin
      if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      if (drv_q[i].size() > 0) begin
        req_valid_i[i]           = ($urandom_range(0, 99) < valid_pct);
        req_data_i[i*DW +: DW]   = drv_q[i][0].data;
        req_last_i[i]            = drv_q[i][0].last;
      end else begin
        req_valid_i[i]           = 1'b0;
        req_data_i[i*DW +: DW]   = $urandom;
        req_last_i[i]            = 1'($urandom_range(0, 1));
      end
    end
    cmd_ready_i = ($urandom_range(0, 99) < ready_pct);
    case (eot_mode)
      0:       spi_eot_i = ($urandom_range(0, 4) == 0);
      1:       spi_eot_i = (m_phase == 2);
      default: spi_eot_i = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid_i = '0; cmd_ready_i = 1'b0; spi_eot_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int i = 0; i < NB_REQ; i++) p += drv_q[i].size() + exp_q[i].size();
    return p;
  endfunction

  initial begin
    int budget;
    bit all_started;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_data_i = '0; req_valid_i = '0; req_last_i = '0;
    cmd_ready_i = 1'b0; spi_eot_i = 1'b0;
    for (int i = 0; i < NB_REQ; i++) started[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic with random EOT pulses (many land outside WAIT_EOT)
    budget = 20000;
    all_started = 1'b0;
    while (budget > 0 && !(all_started && pending() == 0 && m_phase == 0)) begin
      drive_cycle(75, 60, 0);
      all_started = 1'b1;
      for (int i = 0; i < NB_REQ; i++) begin
        if (drv_q[i].size() == 0 && started[i] < N_TXN && $urandom_range(0, 3) == 0)
          new_txn(i, $urandom_range(1, 4));
        if (started[i] < N_TXN) all_started = 1'b0;
      end
      budget--;
    end
    if (budget == 0) chk("random_phase_budget", 1, 0);
    chk("random_sb_drain", pending(), 0);

    // All requesters valid, single-word transactions: rotation 0,1,2,3,0
    do_reset();
    obs_log.delete();
    new_txn(0, 1); new_txn(0, 1); new_txn(1, 1); new_txn(2, 1); new_txn(3, 1);
    budget = 200;
    while (budget > 0 && (pending() != 0 || m_phase != 0)) begin
      drive_cycle(100, 100, 1);
      budget--;
    end
    if (budget == 0) chk("rr_budget", 1, 0);
    chk("rr_count", obs_log.size(), 5);
    for (int k = 0; k < 5 && k < obs_log.size(); k++) chk("rr_order", obs_log[k], exp_rr[k]);

    // Reset while waiting for EOT, then lowest valid index wins from pointer 0
    obs_log.delete();
    new_txn(2, 1);
    budget = 50;
    while (budget > 0 && m_phase != 2) begin
      drive_cycle(100, 100, 2);
      budget--;
    end
    if (budget == 0) chk("wait_eot_budget", 1, 0);
    repeat (3) drive_cycle(100, 100, 2);
    chk("busy_in_wait", busy_o, 1);
    do_reset();
    obs_log.delete();
    new_txn(3, 1); new_txn(1, 1);
    budget = 100;
    while (budget > 0 && (pending() != 0 || m_phase != 0)) begin
      drive_cycle(100, 100, 1);
      budget--;
    end
    if (budget == 0) chk("post_rst_budget", 1, 0);
    chk("post_rst_count", obs_log.size(), 2);
    if (obs_log.size() == 2) begin
      chk("post_rst_first", obs_log[0], 1);
      chk("post_rst_second", obs_log[1], 3);
    end
    repeat (3) drive_cycle(0, 0, 2);
    chk("final_sb_drain", pending(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
